// File: rtl/keypad_pkg.sv
// Shared types and helpers for the debounced keypad encoder.
// The helpers work on a fixed maximum width so any key count up to KEY_MAX_W fits.
package keypad_pkg;

  localparam int KEY_MAX_W = 32;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [KEY_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - KEY_MAX_W'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] onehot2idx(input logic [KEY_MAX_W-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < KEY_MAX_W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous lines.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_encoder_db.sv
// Debounced one-hot keypad encoder: synchronises key lines, waits for a stable pattern,
// reports a single key index or a multi-key error, then waits for a full release.
module keypad_encoder_db
  import keypad_pkg::*;
#(
  parameter int N_KEYS       = 10,
  parameter int CODE_W       = $clog2(N_KEYS),
  parameter int DEBOUNCE_CYC = 4,
  parameter int CNT_W        = $clog2(DEBOUNCE_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_KEYS-1:0] keys,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  localparam logic [CNT_W-1:0] DC_CNT = CNT_W'(DEBOUNCE_CYC);

  generate
    if (N_KEYS < 2 || N_KEYS > KEY_MAX_W) begin : g_bad_keys
      $error("keypad_encoder_db: N_KEYS out of supported range");
    end
    if (N_KEYS > (2 ** CODE_W)) begin : g_bad_code_w
      $error("keypad_encoder_db: CODE_W too narrow for N_KEYS");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
      $error("keypad_encoder_db: DEBOUNCE_CYC must be at least 1");
    end
  endgenerate

  logic [N_KEYS-1:0] keys_s;

  sync_2ff #(.W(N_KEYS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (keys),
    .q     (keys_s)
  );

  state_e              state_q, state_d;
  logic [N_KEYS-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0]   key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                multi_err_q, multi_err_d;
  logic [KEY_MAX_W-1:0] keys_wide;
  logic                settle;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    keys_wide = '0;
    keys_wide[N_KEYS-1:0] = keys_s;
  end

  // settle marks the sample at which the candidate has been stable long enough
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    multi_err_d = 1'b0;
    key_held_d  = key_held_q;
    settle      = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      key_held_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (keys_s != '0) begin
            cand_d  = keys_s;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
            settle  = (DEBOUNCE_CYC == 1);
          end
        end
        DEBOUNCE: begin
          if (keys_s == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (keys_s != cand_q) begin
            cand_d = keys_s;
            cnt_d  = CNT_W'(1);
            settle = (DEBOUNCE_CYC == 1);
          end else begin
            cnt_d  = cnt_inc;
            settle = (cnt_inc == DC_CNT);
          end
        end
        PRESSED: begin
          if (keys_s != cand_q) begin
            state_d    = RELEASE;
            cnt_d      = '0;
            key_held_d = 1'b0;
          end
        end
        RELEASE: begin
          if (keys_s != '0) begin
            cnt_d = '0;
          end else if (cnt_inc == DC_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase

      // keys_s equals the candidate whenever settle is raised
      if (settle) begin
        cnt_d = '0;
        if (is_onehot(keys_wide)) begin
          key_code_d  = CODE_W'(onehot2idx(keys_wide));
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          state_d     = PRESSED;
        end else begin
          multi_err_d = 1'b1;
          state_d     = RELEASE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_encoder_db.sv
// Self-checking bench for keypad_encoder_db: directed scenarios plus random key traffic,
// compared every cycle against a sample-history model of the debounce rules.
module tb_keypad_encoder_db;

  localparam int N_KEYS = 10;
  localparam int CODE_W = 4;
  localparam int DC     = 4;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              en    = 1'b0;
  logic [N_KEYS-1:0] keys  = '0;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_err;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  keypad_encoder_db #(
    .N_KEYS       (N_KEYS),
    .CODE_W       (CODE_W),
    .DEBOUNCE_CYC (DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .keys      (keys),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .multi_err (multi_err)
  );

  initial forever #5 clk = ~clk;

  // Model: what the encoder must do, expressed as runs of identical synchronised samples.
  logic [N_KEYS-1:0] m_s1       = '0;
  logic [N_KEYS-1:0] m_s2       = '0;
  logic [N_KEYS-1:0] m_run_val  = '0;
  logic [N_KEYS-1:0] m_held_val = '0;
  logic [N_KEYS-1:0] m_sample   = '0;
  int                m_run_len  = 0;
  int                m_zero_len = 0;
  bit                m_waiting  = 1'b0;
  logic [CODE_W-1:0] m_code     = '0;
  bit                m_valid    = 1'b0;
  bit                m_err      = 1'b0;
  bit                m_held     = 1'b0;

  function automatic logic [CODE_W-1:0] keyIndex(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_KEYS; i++) if (v[i]) r = CODE_W'(i);
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_run_val = '0; m_held_val = '0;
      m_run_len = 0; m_zero_len = 0; m_waiting = 1'b0;
      m_code = '0; m_valid = 1'b0; m_err = 1'b0; m_held = 1'b0;
    end else begin
      m_sample = m_s2;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      if (!en) begin
        m_run_len = 0; m_held_val = '0; m_waiting = 1'b0; m_zero_len = 0;
      end else if (m_held_val != '0) begin
        if (m_sample != m_held_val) begin
          m_held_val = '0; m_waiting = 1'b1; m_zero_len = 0;
        end
      end else if (m_waiting) begin
        m_zero_len = (m_sample == '0) ? m_zero_len + 1 : 0;
        if (m_zero_len == DC) m_waiting = 1'b0;
      end else begin
        if (m_sample == '0) m_run_len = 0;
        else if (m_run_len > 0 && m_sample == m_run_val) m_run_len++;
        else begin
          m_run_val = m_sample;
          m_run_len = 1;
        end
        if (m_run_len == DC) begin
          m_run_len = 0;
          if ($countones(m_sample) == 1) begin
            m_valid = 1'b1; m_code = keyIndex(m_sample); m_held_val = m_sample;
          end else begin
            m_err = 1'b1; m_waiting = 1'b1; m_zero_len = 0;
          end
        end
      end
      m_held = (m_held_val != '0);
      m_s2   = m_s1;
      m_s1   = keys;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Sets the inputs just after an edge, then watches the following edges (edge 1 = first one).
  task automatic applyStimulus(input logic [N_KEYS-1:0] k, input logic e, input int cycles,
                               output int first_valid, output int n_valid,
                               output int first_err, output int n_err);
    first_valid = 0; n_valid = 0; first_err = 0; n_err = 0;
    keys = k;
    en   = e;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      #1;
      if (key_valid === 1'b1) begin
        n_valid++;
        if (first_valid == 0) first_valid = c;
      end
      if (multi_err === 1'b1) begin
        n_err++;
        if (first_err == 0) first_err = c;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("cmp_key_valid", 32'(key_valid), 32'(m_valid));
      checkOutput("cmp_multi_err", 32'(multi_err), 32'(m_err));
      checkOutput("cmp_key_held",  32'(key_held),  32'(m_held));
      checkOutput("cmp_key_code",  32'(key_code),  32'(m_code));
    end
  end

  int fv, nv, fe, ne, tot_v;

  initial begin
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_key_code",  32'(key_code),  0);
    checkOutput("rst_key_valid", 32'(key_valid), 0);
    checkOutput("rst_key_held",  32'(key_held),  0);
    checkOutput("rst_multi_err", 32'(multi_err), 0);
    rst_n = 1'b1;

    // Clean press of key 5, then release
    applyStimulus(10'h020, 1'b1, 20, fv, nv, fe, ne);
    checkOutput("press_latency", fv, 6);
    checkOutput("press_pulses", nv, 1);
    checkOutput("press_no_err", ne, 0);
    checkOutput("press_code", 32'(key_code), 5);
    checkOutput("press_held", 32'(key_held), 1);
    applyStimulus(10'h000, 1'b1, 2, fv, nv, fe, ne);
    checkOutput("release_held_edge2", 32'(key_held), 1);
    applyStimulus(10'h000, 1'b1, 1, fv, nv, fe, ne);
    checkOutput("release_held_edge3", 32'(key_held), 0);
    applyStimulus(10'h000, 1'b1, 8, fv, nv, fe, ne);

    // Asynchronous reset in the middle of debouncing key 3
    applyStimulus(10'h008, 1'b1, 4, fv, nv, fe, ne);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_code",  32'(key_code),  0);
    checkOutput("async_rst_valid", 32'(key_valid), 0);
    checkOutput("async_rst_held",  32'(key_held),  0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(10'h008, 1'b1, 10, fv, nv, fe, ne);
    checkOutput("post_rst_latency", fv, 6);
    checkOutput("post_rst_code", 32'(key_code), 3);
    applyStimulus(10'h000, 1'b1, 10, fv, nv, fe, ne);

    // Bouncing key 1 settles into one accept
    tot_v = 0;
    for (int b = 0; b < 5; b++) begin
      applyStimulus((b % 2 == 0) ? 10'h002 : 10'h000, 1'b1, 2, fv, nv, fe, ne);
      tot_v += nv;
    end
    applyStimulus(10'h002, 1'b1, 20, fv, nv, fe, ne);
    tot_v += nv;
    checkOutput("bounce_pulses", tot_v, 1);
    checkOutput("bounce_code", 32'(key_code), 1);
    applyStimulus(10'h000, 1'b1, 10, fv, nv, fe, ne);

    // Two keys at once, then the release-length boundary
    applyStimulus(10'h201, 1'b1, 12, fv, nv, fe, ne);
    checkOutput("multi_latency", fe, 6);
    checkOutput("multi_pulses", ne, 1);
    checkOutput("multi_no_valid", nv, 0);
    applyStimulus(10'h000, 1'b1, 3, fv, nv, fe, ne);
    applyStimulus(10'h010, 1'b1, 12, fv, nv, fe, ne);
    checkOutput("short_release_blocks", nv, 0);
    applyStimulus(10'h000, 1'b1, 4, fv, nv, fe, ne);
    applyStimulus(10'h010, 1'b1, 12, fv, nv, fe, ne);
    checkOutput("full_release_latency", fv, 6);
    checkOutput("full_release_code", 32'(key_code), 4);
    applyStimulus(10'h000, 1'b1, 10, fv, nv, fe, ne);

    // Enable gating
    applyStimulus(10'h004, 1'b0, 12, fv, nv, fe, ne);
    checkOutput("en_off_no_valid", nv, 0);
    checkOutput("en_off_no_held", 32'(key_held), 0);
    applyStimulus(10'h004, 1'b1, 10, fv, nv, fe, ne);
    checkOutput("en_on_latency", fv, 4);
    checkOutput("en_on_code", 32'(key_code), 2);
    applyStimulus(10'h004, 1'b0, 1, fv, nv, fe, ne);
    checkOutput("en_drop_held", 32'(key_held), 0);
    checkOutput("en_drop_code", 32'(key_code), 2);
    applyStimulus(10'h000, 1'b0, 4, fv, nv, fe, ne);
    applyStimulus(10'h000, 1'b1, 6, fv, nv, fe, ne);

    // Re-press before the release has completed
    applyStimulus(10'h020, 1'b1, 12, fv, nv, fe, ne);
    applyStimulus(10'h000, 1'b1, 2, fv, nv, fe, ne);
    applyStimulus(10'h200, 1'b1, 12, fv, nv, fe, ne);
    checkOutput("repress_blocked", nv, 0);
    checkOutput("repress_code_kept", 32'(key_code), 5);
    applyStimulus(10'h000, 1'b1, 8, fv, nv, fe, ne);
    applyStimulus(10'h200, 1'b1, 12, fv, nv, fe, ne);
    checkOutput("repress_latency", fv, 6);
    checkOutput("repress_code", 32'(key_code), 9);
    applyStimulus(10'h000, 1'b1, 10, fv, nv, fe, ne);

    // Random key traffic against the model
    for (int it = 0; it < 300; it++) begin
      logic [N_KEYS-1:0] k;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 2)      k = '0;
      else if (sel <= 6) k = N_KEYS'(1) << $urandom_range(0, N_KEYS - 1);
      else if (sel <= 8) k = (N_KEYS'(1) << $urandom_range(0, N_KEYS - 1))
                           | (N_KEYS'(1) << $urandom_range(0, N_KEYS - 1));
      else               k = N_KEYS'($urandom);
      applyStimulus(k, ($urandom_range(0, 9) != 0), $urandom_range(1, 10), fv, nv, fe, ne);
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
